copperv_io_responder: RTL and testbench

Synthesizable memory-mapped IO target for the copperv data read (dr) and data write (dw) buses. It replaces the behavioural fake IO used in simulation so the same programs run on FPGA.
- Provides a test-status register.
- Provides a UART transmit path: 8-entry TX FIFO plus 8N1 serializer.
- Provides a read-only status register.
- Sits on the dr/dw ports behind the crossbar, acting as responder to the CPU initiator.

---
 rtl/copperv_io_pkg.sv | 32 +++
 rtl/copperv_uart_tx.sv | 104 ++++++++++
 rtl/copperv_io_responder.sv | 194 +++++++++++++++++++
 tb/tb_copperv_io_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/copperv_io_pkg.sv
// Shared constants for the copperv IO responder: register offsets, response
// codes, test status codes, STATUS bit positions and serializer states.
package copperv_io_pkg;

    localparam int BUS_RESP_WIDTH = 1;

    localparam logic [31:0] TEST_OFF    = 32'd0;
    localparam logic [31:0] UART_TX_OFF = 32'd4;
    localparam logic [31:0] STATUS_OFF  = 32'd8;

    localparam logic [BUS_RESP_WIDTH-1:0] RESP_OK  = 1'b0;
    localparam logic [BUS_RESP_WIDTH-1:0] RESP_ERR = 1'b1;

    localparam logic [31:0] PASS_CODE = 32'h0100_0001;
    localparam logic [31:0] FAIL_CODE = 32'h0200_0001;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // A word write only counts when every byte lane is enabled.
    function automatic logic strobe_full(input logic [3:0] strobe);
        return &strobe;
    endfunction

endpackage

// File: rtl/copperv_uart_tx.sv
// 8N1 serializer. Pulls bytes from the TX FIFO through a pop/data/empty
// interface; a new frame starts straight out of STOP when more data waits.
module copperv_uart_tx
    import copperv_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_pop,
    output logic       tx,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [1:0]    state_r;
    logic [CW-1:0] baud_r;
    logic [2:0]    bit_r;
    logic [7:0]    shift_r;
    logic          baud_done_s;

    assign baud_done_s = (baud_r == CW'(CLKS_PER_BIT - 1));
    assign busy        = (state_r != ST_IDLE);

    // Pop request: idle with data, or last cycle of a stop bit with data waiting.
    always_comb begin
        fifo_pop = 1'b0;
        case (state_r)
            ST_IDLE: fifo_pop = !fifo_empty;
            ST_STOP: fifo_pop = !fifo_empty && baud_done_s;
            default: fifo_pop = 1'b0;
        endcase
    end

    // Frame sequencing, baud/bit counters and the registered line output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            baud_r  <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            tx      <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    baud_r <= '0;
                    if (fifo_pop) begin
                        state_r <= ST_START;
                        shift_r <= fifo_data;
                        tx      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_done_s) begin
                        state_r <= ST_DATA;
                        baud_r  <= '0;
                        bit_r   <= 3'd0;
                        tx      <= shift_r[0];
                    end else begin
                        baud_r <= baud_r + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_done_s) begin
                        baud_r <= '0;
                        if (bit_r == 3'd7) begin
                            state_r <= ST_STOP;
                            tx      <= 1'b1;
                        end else begin
                            bit_r   <= bit_r + 3'd1;
                            shift_r <= {1'b0, shift_r[7:1]};
                            tx      <= shift_r[1];
                        end
                    end else begin
                        baud_r <= baud_r + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_done_s) begin
                        baud_r <= '0;
                        if (fifo_pop) begin
                            state_r <= ST_START;
                            shift_r <= fifo_data;
                            tx      <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        baud_r <= baud_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    baud_r  <= '0;
                    tx      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/copperv_io_responder.sv
// Memory-mapped IO responder on the copperv dr/dw buses: test-status register,
// UART TX FIFO feeding an 8N1 serializer, and a read-only STATUS register.
module copperv_io_responder
    import copperv_io_pkg::*;
#(
    parameter int                   BUS_WIDTH    = 32,
    parameter logic [BUS_WIDTH-1:0] BASE_ADDR    = 32'h0000_8000,
    parameter int                   FIFO_DEPTH   = 8,
    parameter int                   CLKS_PER_BIT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      dr_addr_valid,
    output logic                      dr_addr_ready,
    input  logic [BUS_WIDTH-1:0]      dr_addr,
    output logic                      dr_data_valid,
    input  logic                      dr_data_ready,
    output logic [BUS_WIDTH-1:0]      dr_data,
    input  logic                      dw_data_addr_valid,
    output logic                      dw_data_addr_ready,
    input  logic [BUS_WIDTH-1:0]      dw_addr,
    input  logic [BUS_WIDTH-1:0]      dw_data,
    input  logic [BUS_WIDTH/8-1:0]    dw_strobe,
    output logic                      dw_resp_valid,
    input  logic                      dw_resp_ready,
    output logic [BUS_RESP_WIDTH-1:0] dw_resp,
    output logic                      uart_tx,
    output logic                      test_done,
    output logic                      test_pass
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [BUS_WIDTH-1:0] TEST_ADDR   = BASE_ADDR + BUS_WIDTH'(TEST_OFF);
    localparam logic [BUS_WIDTH-1:0] UART_ADDR   = BASE_ADDR + BUS_WIDTH'(UART_TX_OFF);
    localparam logic [BUS_WIDTH-1:0] STATUS_ADDR = BASE_ADDR + BUS_WIDTH'(STATUS_OFF);

    logic [AW:0]                wr_ptr_r, rd_ptr_r;
    logic [7:0]                 fifo_mem_r [FIFO_DEPTH];
    logic                       fifo_empty_s, fifo_full_s, fifo_push_s, fifo_pop_s;
    logic                       overflow_r, ovf_set_s;
    logic [BUS_WIDTH-1:0]       test_code_r;
    logic                       test_wr_s;
    logic                       dw_fire_s, dr_fire_s;
    logic [BUS_RESP_WIDTH-1:0]  wr_resp_s;
    logic [BUS_WIDTH-1:0]       rd_val_s, status_s;
    logic                       tx_busy_s;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                          (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign dw_fire_s    = dw_data_addr_valid && dw_data_addr_ready;
    assign dr_fire_s    = dr_addr_valid && dr_addr_ready;

    // Write decode: side effects and response code for the accepted request.
    always_comb begin
        fifo_push_s = 1'b0;
        ovf_set_s   = 1'b0;
        test_wr_s   = 1'b0;
        wr_resp_s   = RESP_ERR;
        if (dw_addr == TEST_ADDR) begin
            if (strobe_full(4'(dw_strobe))) begin
                test_wr_s = dw_fire_s;
                wr_resp_s = RESP_OK;
            end else begin
                wr_resp_s = RESP_ERR;
            end
        end else if (dw_addr == UART_ADDR) begin
            if (!dw_strobe[0]) begin
                wr_resp_s = RESP_OK;
            end else if (fifo_full_s) begin
                ovf_set_s = dw_fire_s;
                wr_resp_s = RESP_ERR;
            end else begin
                fifo_push_s = dw_fire_s;
                wr_resp_s   = RESP_OK;
            end
        end else begin
            wr_resp_s = RESP_ERR;
        end
    end

    // Read decode from current (pre-update) state.
    always_comb begin
        status_s             = '0;
        status_s[STAT_FULL]  = fifo_full_s;
        status_s[STAT_EMPTY] = fifo_empty_s;
        status_s[STAT_BUSY]  = tx_busy_s;
        status_s[STAT_OVF]   = overflow_r;
        if (dr_addr == TEST_ADDR) begin
            rd_val_s = test_code_r;
        end else if (dr_addr == STATUS_ADDR) begin
            rd_val_s = status_s;
        end else begin
            rd_val_s = '0;
        end
    end

    // Write channel: one outstanding request, response held until taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dw_resp_valid      <= 1'b0;
            dw_resp            <= RESP_OK;
            dw_data_addr_ready <= 1'b0;
        end else if (dw_fire_s) begin
            dw_resp_valid      <= 1'b1;
            dw_resp            <= wr_resp_s;
            dw_data_addr_ready <= 1'b0;
        end else if (dw_resp_valid && dw_resp_ready) begin
            dw_resp_valid      <= 1'b0;
            dw_data_addr_ready <= 1'b1;
        end else begin
            dw_data_addr_ready <= !dw_resp_valid;
        end
    end

    // Read channel: snapshot data on accept, hold until taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dr_data_valid <= 1'b0;
            dr_data       <= '0;
            dr_addr_ready <= 1'b0;
        end else if (dr_fire_s) begin
            dr_data_valid <= 1'b1;
            dr_data       <= rd_val_s;
            dr_addr_ready <= 1'b0;
        end else if (dr_data_valid && dr_data_ready) begin
            dr_data_valid <= 1'b0;
            dr_addr_ready <= 1'b1;
        end else begin
            dr_addr_ready <= !dr_data_valid;
        end
    end

    // Test-status register; test_done is sticky once any valid write lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            test_code_r <= '0;
            test_done   <= 1'b0;
            test_pass   <= 1'b0;
        end else if (test_wr_s) begin
            test_code_r <= dw_data;
            test_done   <= 1'b1;
            test_pass   <= (dw_data == BUS_WIDTH'(PASS_CODE));
        end else begin
            test_code_r <= test_code_r;
        end
    end

    // FIFO pointers and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (fifo_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (fifo_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (fifo_push_s) begin
            fifo_mem_r[wr_ptr_r[AW-1:0]] <= dw_data[7:0];
        end
    end

    copperv_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty_s),
        .fifo_data (fifo_mem_r[rd_ptr_r[AW-1:0]]),
        .fifo_pop  (fifo_pop_s),
        .tx        (uart_tx),
        .busy      (tx_busy_s)
    );

endmodule

// File: tb/tb_copperv_io_responder.sv
// Scenario testbench for copperv_io_responder with a queue-based scoreboard.
module tb_copperv_io_responder;

    localparam logic [31:0] BASE = 32'h0000_8000;
    localparam logic        OK   = 1'b0;
    localparam logic        ERR  = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dr_addr_valid = 1'b0, dr_addr_ready, dr_data_valid, dr_data_ready = 1'b1;
    logic [31:0] dr_addr = 32'h0, dr_data;
    logic        dw_data_addr_valid = 1'b0, dw_data_addr_ready, dw_resp_valid, dw_resp_ready = 1'b1;
    logic [31:0] dw_addr = 32'h0, dw_data = 32'h0;
    logic [3:0]  dw_strobe = 4'h0;
    logic [0:0]  dw_resp;
    logic        uart_tx, test_done, test_pass;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic        wq[$];
    logic [31:0] rq[$];
    logic [7:0]  uq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    copperv_io_responder #(.CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst),
        .dr_addr_valid(dr_addr_valid), .dr_addr_ready(dr_addr_ready), .dr_addr(dr_addr),
        .dr_data_valid(dr_data_valid), .dr_data_ready(dr_data_ready), .dr_data(dr_data),
        .dw_data_addr_valid(dw_data_addr_valid), .dw_data_addr_ready(dw_data_addr_ready),
        .dw_addr(dw_addr), .dw_data(dw_data), .dw_strobe(dw_strobe),
        .dw_resp_valid(dw_resp_valid), .dw_resp_ready(dw_resp_ready), .dw_resp(dw_resp),
        .uart_tx(uart_tx), .test_done(test_done), .test_pass(test_pass)
    );

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic er, input string nm);
        int n;
        logic e;
        wq.push_back(er);
        dw_addr = a; dw_data = d; dw_strobe = s; dw_data_addr_valid = 1'b1;
        n = 0;
        while (dw_data_addr_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        total++;
        if (n >= 100) begin bad++; $display("FAIL %s accept timeout ready=%b", nm, dw_data_addr_ready); end
        @(negedge clk);
        dw_data_addr_valid = 1'b0;
        total++;
        if (dw_resp_valid !== 1'b1) begin bad++; $display("FAIL %s resp_valid got=%b want=1", nm, dw_resp_valid); end
        e = wq.pop_front();
        total++;
        if (dw_resp !== e) begin bad++; $display("FAIL %s resp got=%b want=%b", nm, dw_resp, e); end
        @(negedge clk);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] ev, input string nm);
        int n;
        logic [31:0] e;
        rq.push_back(ev);
        dr_addr = a; dr_addr_valid = 1'b1;
        n = 0;
        while (dr_addr_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        total++;
        if (n >= 100) begin bad++; $display("FAIL %s accept timeout ready=%b", nm, dr_addr_ready); end
        @(negedge clk);
        dr_addr_valid = 1'b0;
        total++;
        if (dr_data_valid !== 1'b1) begin bad++; $display("FAIL %s data_valid got=%b want=1", nm, dr_data_valid); end
        e = rq.pop_front();
        total++;
        if (dr_data !== e) begin bad++; $display("FAIL %s data got=%h want=%h", nm, dr_data, e); end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({dr_addr_ready, dw_data_addr_ready, dr_data_valid, dw_resp_valid} !== 4'b0000) begin
            bad++; $display("FAIL reset_handshake got=%b want=0000",
                {dr_addr_ready, dw_data_addr_ready, dr_data_valid, dw_resp_valid});
        end
        total++;
        if (dr_data !== 32'h0 || dw_resp !== OK) begin
            bad++; $display("FAIL reset_data got=%h/%b want=0/0", dr_data, dw_resp);
        end
        total++;
        if ({uart_tx, test_done, test_pass} !== 3'b100) begin
            bad++; $display("FAIL reset_outs got=%b want=100", {uart_tx, test_done, test_pass});
        end
        rst = 1'b1;
        @(negedge clk);
        do_read(BASE + 32'd8, 32'h2, "reset_status");
    endtask

    task automatic test_test_reg();
        do_write(BASE, 32'h0100_0001, 4'hF, OK, "test_pass_wr");
        total++;
        if ({test_done, test_pass} !== 2'b11) begin bad++; $display("FAIL test_pass_flags got=%b want=11", {test_done, test_pass}); end
        do_read(BASE, 32'h0100_0001, "test_pass_rd");
        do_write(BASE, 32'h0000_BEEF, 4'hF, OK, "test_beef_wr");
        total++;
        if ({test_done, test_pass} !== 2'b10) begin bad++; $display("FAIL test_beef_flags got=%b want=10", {test_done, test_pass}); end
        do_write(BASE, 32'h0100_0001, 4'h3, ERR, "test_partial_wr");
        total++;
        if ({test_done, test_pass} !== 2'b10) begin bad++; $display("FAIL test_partial_flags got=%b want=10", {test_done, test_pass}); end
        do_read(BASE, 32'h0000_BEEF, "test_partial_rd");
        do_write(BASE, 32'h0200_0001, 4'hF, OK, "test_failcode_wr");
        total++;
        if ({test_done, test_pass} !== 2'b10) begin bad++; $display("FAIL test_failcode_flags got=%b want=10", {test_done, test_pass}); end
    endtask

    task automatic test_uart_frame();
        logic [7:0] b;
        b = 8'h41;
        do_write(BASE + 32'd4, 32'h41, 4'hF, OK, "uart_wr");
        fork
            begin
                logic expb;
                for (int j = 0; j < 40; j++) begin
                    if (j < 4) expb = 1'b0;
                    else if (j < 36) expb = b[(j - 4) / 4];
                    else expb = 1'b1;
                    total++;
                    if (uart_tx !== expb) begin bad++; $display("FAIL uart_bit sample=%0d got=%b want=%b", j, uart_tx, expb); end
                    @(negedge clk);
                end
            end
            begin
                repeat (8) @(negedge clk);
                do_read(BASE + 32'd8, 32'h6, "uart_status_busy");
            end
        join
    endtask

    task automatic test_overflow();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    if (i < 9) uq.push_back(8'(8'h10 + i));
                    do_write(BASE + 32'd4, 32'h10 + i, 4'hF, (i < 9) ? OK : ERR, "ovf_wr");
                end
                do_read(BASE + 32'd8, 32'hD, "ovf_status");
            end
            begin
                int prev;
                int n;
                logic [7:0] got;
                logic [7:0] e;
                prev = 0;
                for (int f = 0; f < 9; f++) begin
                    n = 0;
                    while (uart_tx !== 1'b0 && n < 200) begin @(negedge clk); n++; end
                    total++;
                    if (n >= 200) begin bad++; $display("FAIL ovf_frame_start frame=%0d timeout", f); end
                    if (f > 0) begin
                        total++;
                        if (cyc - prev != 40) begin bad++; $display("FAIL ovf_spacing frame=%0d got=%0d want=40", f, cyc - prev); end
                    end
                    prev = cyc;
                    got = 8'h00;
                    for (int j = 0; j < 40; j++) begin
                        if (j == 2) begin
                            total++;
                            if (uart_tx !== 1'b0) begin bad++; $display("FAIL ovf_startbit frame=%0d got=%b want=0", f, uart_tx); end
                        end else if (j == 38) begin
                            total++;
                            if (uart_tx !== 1'b1) begin bad++; $display("FAIL ovf_stopbit frame=%0d got=%b want=1", f, uart_tx); end
                        end else if (j % 4 == 2) begin
                            got[(j - 6) / 4] = uart_tx;
                        end
                        @(negedge clk);
                    end
                    e = (uq.size() > 0) ? uq.pop_front() : 8'hXX;
                    total++;
                    if (got !== e) begin bad++; $display("FAIL ovf_byte frame=%0d got=%h want=%h", f, got, e); end
                end
            end
        join
        repeat (10) @(negedge clk);
        total++;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL ovf_tenth_frame uart got=%b want=1", uart_tx); end
        do_read(BASE + 32'd8, 32'hA, "ovf_status_drained");
    endtask

    task automatic test_stall_unmapped();
        int n;
        logic e;
        dw_resp_ready = 1'b0;
        wq.push_back(ERR);
        dw_addr = 32'h9000; dw_data = 32'h1234; dw_strobe = 4'hF; dw_data_addr_valid = 1'b1;
        n = 0;
        while (dw_data_addr_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        dw_data_addr_valid = 1'b0;
        e = wq.pop_front();
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({dw_resp_valid, dw_data_addr_ready, dw_resp} !== {1'b1, 1'b0, e}) begin
                bad++; $display("FAIL stall_hold cycle=%0d got=%b want=%b", k,
                    {dw_resp_valid, dw_data_addr_ready, dw_resp}, {1'b1, 1'b0, e});
            end
            @(negedge clk);
        end
        dw_resp_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({dw_resp_valid, dw_data_addr_ready} !== 2'b01) begin
            bad++; $display("FAIL stall_release got=%b want=01", {dw_resp_valid, dw_data_addr_ready});
        end
        do_read(32'h9000, 32'h0, "unmapped_rd");
        do_read(BASE + 32'd4, 32'h0, "uart_reg_rd");
        do_write(BASE + 32'd8, 32'hFF, 4'hF, ERR, "status_wr");
        do_write(BASE + 32'd4, 32'h55, 4'hE, OK, "uart_nolane0_wr");
        repeat (4) @(negedge clk);
        total++;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL uart_nolane0_line got=%b want=1", uart_tx); end
        do_read(BASE + 32'd8, 32'hA, "uart_nolane0_status");
    endtask

    task automatic test_reset_midframe();
        do_write(BASE + 32'd4, 32'h00, 4'hF, OK, "mid_wr");
        repeat (3) @(negedge clk);
        dr_data_ready = 1'b0;
        dr_addr = BASE; dr_addr_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dr_addr_valid = 1'b0;
        total++;
        if ({uart_tx, dr_data_valid} !== 2'b01) begin
            bad++; $display("FAIL mid_prereset got=%b want=01", {uart_tx, dr_data_valid});
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if ({uart_tx, dr_data_valid, dw_resp_valid, test_done} !== 4'b1000) begin
            bad++; $display("FAIL mid_reset got=%b want=1000", {uart_tx, dr_data_valid, dw_resp_valid, test_done});
        end
        @(negedge clk);
        rst = 1'b1;
        dr_data_ready = 1'b1;
        @(negedge clk);
        do_read(BASE + 32'd8, 32'h2, "mid_status");
        do_read(BASE, 32'h0, "mid_testcode");
        repeat (8) @(negedge clk);
        total++;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL mid_line_idle got=%b want=1", uart_tx); end
    endtask

    initial begin
        test_reset();
        test_test_reg();
        test_uart_frame();
        test_overflow();
        test_stall_unmapped();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
